// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI constants, FSM state types and address-decode helpers for the SRAM slave.
package axi_sram_slave_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                           input logic [31:0] depth_words);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> 2) < depth_words);
    endfunction

    // Unsupported size or WRAP/reserved burst: every beat of the transaction is an error.
    function automatic logic ctrl_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != AXI_SIZE_4B) || burst[1];
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 channel bundle between a DMA master and the SRAM slave.
interface axi_sram_slave_if;
    logic [3:0]  awid_i;
    logic [31:0] awaddr_i;
    logic [3:0]  awlen_i;
    logic [2:0]  awsize_i;
    logic [1:0]  awburst_i;
    logic        awvalid_i;
    logic        awready_o;
    logic [3:0]  wid_i;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        wlast_i;
    logic        wvalid_i;
    logic        wready_o;
    logic [3:0]  bid_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i;
    logic [3:0]  arid_i;
    logic [31:0] araddr_i;
    logic [3:0]  arlen_i;
    logic [2:0]  arsize_i;
    logic [1:0]  arburst_i;
    logic        arvalid_i;
    logic        arready_o;
    logic [3:0]  rid_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic        rvalid_o;
    logic        rready_i;

    modport slave (
        input  awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
        input  wid_i, wdata_i, wstrb_i, wlast_i, wvalid_i, bready_i,
        input  arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
        output awready_o, wready_o, bid_o, bresp_o, bvalid_o,
        output arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
    );

    modport master (
        output awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
        output wid_i, wdata_i, wstrb_i, wlast_i, wvalid_i, bready_i,
        output arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
        input  awready_o, wready_o, bid_o, bresp_o, bvalid_o,
        input  arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
    );
endinterface

// File: rtl/axi_sram_slave_mem.sv
// DEPTH x 32 SRAM: one byte-enabled write port, one combinational read port (old data on same-word collision).
module axi_sram_slave_mem #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [31:0]              rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[ridx];
endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 SRAM responder: independent single-outstanding read and write FSMs over axi_sram_slave_mem.
//  state  | meaning
//  W_IDLE | awready high, waiting for AW      W_DATA | wready high, accepting beats
//  W_RESP | bvalid high until bready          R_IDLE | arready high, waiting for AR
//  R_DATA | rvalid high, one beat per R handshake
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024
) (
    input logic             clk,
    input logic             rst,
    axi_sram_slave_if.slave s
);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - BASE_ADDR) >> 2;
        return off[IDX_W-1:0];
    endfunction

    wstate_t     w_state_q, w_state_d;
    logic [3:0]  w_id_q, w_id_d, w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic        w_incr_q, w_incr_d, w_bad_q, w_bad_d, w_err_q, w_err_d;
    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [3:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;

    rstate_t     r_state_q, r_state_d;
    logic [3:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic        r_incr_q, r_incr_d, r_bad_q, r_bad_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [3:0]  rid_q, rid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic        w_hs, w_beat_ok, w_last_beat, w_err_nxt, mem_we;
    logic        ar_hs, r_adv, r_ld, r_ld_bad;
    logic [31:0] r_ld_addr, mem_rdata;
    logic [3:0]  r_ld_cnt, r_ld_len;

    assign w_hs        = (w_state_q == W_DATA) && s.wvalid_i && wready_q;
    assign w_beat_ok   = addr_in_range(w_addr_q, BASE_ADDR, DEPTH_W) && !w_bad_q;
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_err_nxt   = w_err_q || !w_beat_ok || (s.wlast_i != w_last_beat);
    assign mem_we      = w_hs && w_beat_ok;

    // The next read beat is fetched combinationally so it lands in rdata_q on the handshake edge.
    assign ar_hs     = (r_state_q == R_IDLE) && s.arvalid_i && arready_q;
    assign r_adv     = (r_state_q == R_DATA) && s.rready_i && !rlast_q;
    assign r_ld      = ar_hs || r_adv;
    assign r_ld_addr = ar_hs ? s.araddr_i : (r_incr_q ? r_addr_q + 32'd4 : r_addr_q);
    assign r_ld_bad  = ar_hs ? ctrl_bad(s.arsize_i, s.arburst_i) : r_bad_q;
    assign r_ld_len  = ar_hs ? s.arlen_i : r_len_q;
    assign r_ld_cnt  = ar_hs ? 4'd0 : r_cnt_q + 4'd1;

    axi_sram_slave_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .widx  (word_idx(w_addr_q)),
        .wdata (s.wdata_i),
        .wstrb (s.wstrb_i),
        .ridx  (word_idx(r_ld_addr)),
        .rdata (mem_rdata)
    );

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_addr_d  = w_addr_q;
        w_incr_d  = w_incr_q;
        w_bad_d   = w_bad_q;
        w_err_d   = w_err_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: if (s.awvalid_i && awready_q) begin
                w_id_d    = s.awid_i;
                w_addr_d  = s.awaddr_i;
                w_len_d   = s.awlen_i;
                w_incr_d  = (s.awburst_i == AXI_BURST_INCR);
                w_bad_d   = ctrl_bad(s.awsize_i, s.awburst_i);
                w_cnt_d   = 4'd0;
                w_err_d   = 1'b0;
                awready_d = 1'b0;
                wready_d  = 1'b1;
                w_state_d = W_DATA;
            end
            W_DATA: if (w_hs) begin
                w_err_d = w_err_nxt;
                w_cnt_d = w_cnt_q + 4'd1;
                if (w_incr_q) w_addr_d = w_addr_q + 32'd4;
                if (w_last_beat) begin
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bid_d     = w_id_q;
                    bresp_d   = w_err_nxt ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: if (s.bready_i) begin
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_addr_d  = r_addr_q;
        r_incr_d  = r_incr_q;
        r_bad_d   = r_bad_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (ar_hs) begin
            r_len_d   = s.arlen_i;
            r_incr_d  = (s.arburst_i == AXI_BURST_INCR);
            r_bad_d   = r_ld_bad;
            rid_d     = s.arid_i;
            arready_d = 1'b0;
            rvalid_d  = 1'b1;
            r_state_d = R_DATA;
        end else if ((r_state_q == R_DATA) && s.rready_i && rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
        end
        if (r_ld) begin
            r_addr_d = r_ld_addr;
            r_cnt_d  = r_ld_cnt;
            rlast_d  = (r_ld_cnt == r_ld_len);
            if (addr_in_range(r_ld_addr, BASE_ADDR, DEPTH_W) && !r_ld_bad) begin
                rdata_d = mem_rdata;
                rresp_d = AXI_RESP_OKAY;
            end else begin
                rdata_d = 32'd0;
                rresp_d = AXI_RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bresp_q   <= 2'd0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 4'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'd0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_addr_q  <= w_addr_d;
            w_incr_q  <= w_incr_d;
            w_bad_q   <= w_bad_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_addr_q  <= r_addr_d;
            r_incr_q  <= r_incr_d;
            r_bad_q   <= r_bad_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s.awready_o = awready_q;
    assign s.wready_o  = wready_q;
    assign s.bvalid_o  = bvalid_q;
    assign s.bid_o     = bid_q;
    assign s.bresp_o   = bresp_q;
    assign s.arready_o = arready_q;
    assign s.rvalid_o  = rvalid_q;
    assign s.rlast_o   = rlast_q;
    assign s.rid_o     = rid_q;
    assign s.rdata_o   = rdata_q;
    assign s.rresp_o   = rresp_q;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed and randomized AXI traffic against a word-array reference model of the SRAM slave.
module tb_axi_sram_slave;
    import axi_sram_slave_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_sram_slave_if bus();
    axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .s(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a >= BASE) && ((off / 4) < DEPTH);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int k);
        return (burst == 2'b01) ? a + 32'(4 * k) : a;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input logic [31:0] data [16], input logic [3:0] strb [16],
                             input bit wlast_flip, input int bdelay, output int b_lat);
        int n, c0;
        bit err, ctrl_err, ok;
        logic [31:0] a;
        ctrl_err = (size != 3'b010) || burst[1];
        err = 0;
        @(negedge clk);
        bus.awid_i = id; bus.awaddr_i = addr; bus.awlen_i = len;
        bus.awburst_i = burst; bus.awsize_i = size; bus.awvalid_i = 1;
        n = 0;
        while (!bus.awready_o && n < 100) begin @(negedge clk); n++; end
        chk("aw_ready", bus.awready_o, 1'b1);
        c0 = cyc;
        @(negedge clk);
        bus.awvalid_i = 0;
        for (int k = 0; k <= int'(len); k++) begin
            bus.wvalid_i = 1; bus.wdata_i = data[k]; bus.wstrb_i = strb[k];
            bus.wid_i = id;
            bus.wlast_i = (k == int'(len)) ^ (wlast_flip && k == 0);
            n = 0;
            while (!bus.wready_o && n < 100) begin @(negedge clk); n++; end
            chk("w_ready", bus.wready_o, 1'b1);
            a  = beat_addr(addr, burst, k);
            ok = model_ok(a) && !ctrl_err;
            if (ok)
                for (int b = 0; b < 4; b++)
                    if (strb[k][b]) ref_mem[widx(a)][8*b +: 8] = data[k][8*b +: 8];
            err = err || !ok || (bus.wlast_i != (k == int'(len)));
            @(negedge clk);
        end
        bus.wvalid_i = 0; bus.wlast_i = 0;
        n = 0;
        while (!bus.bvalid_o && n < 100) begin @(negedge clk); n++; end
        b_lat = cyc - c0;
        chk("b_valid", bus.bvalid_o, 1'b1);
        chk("b_id", bus.bid_o, id);
        chk("b_resp", bus.bresp_o, err ? 2'b10 : 2'b00);
        for (int d = 0; d < bdelay; d++) begin
            @(negedge clk);
            chk("b_hold", {bus.bvalid_o, bus.bid_o, bus.bresp_o}, {1'b1, id, err ? 2'b10 : 2'b00});
        end
        bus.bready_i = 1;
        @(negedge clk);
        bus.bready_i = 0;
        chk("b_drop", bus.bvalid_o, 1'b0);
        chk("aw_ready_back", bus.awready_o, 1'b1);
    endtask

    // mode 0: rready always high, 1: toggling, 2: random
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int mode,
                            output int r_lat, output int span, output logic [31:0] d0);
        logic [31:0] exp_d [16];
        logic [1:0]  exp_r [16];
        logic [34:0] held;
        logic [31:0] a;
        bit ctrl_err, ok, stalled, rr;
        int n, k, c0, first, last_hs;
        ctrl_err = (size != 3'b010) || burst[1];
        for (int i = 0; i <= int'(len); i++) begin
            a  = beat_addr(addr, burst, i);
            ok = model_ok(a) && !ctrl_err;
            exp_d[i] = ok ? ref_mem[widx(a)] : 32'd0;
            exp_r[i] = ok ? 2'b00 : 2'b10;
        end
        @(negedge clk);
        bus.arid_i = id; bus.araddr_i = addr; bus.arlen_i = len;
        bus.arburst_i = burst; bus.arsize_i = size; bus.arvalid_i = 1;
        n = 0;
        while (!bus.arready_o && n < 100) begin @(negedge clk); n++; end
        chk("ar_ready", bus.arready_o, 1'b1);
        c0 = cyc;
        @(negedge clk);
        bus.arvalid_i = 0;
        k = 0; n = 0; first = -1; last_hs = 0; stalled = 0; held = '0; d0 = '0;
        while (k <= int'(len) && n < 300) begin
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(n % 2) : bit'($urandom_range(0, 1));
            bus.rready_i = rr;
            if (bus.rvalid_o) begin
                if (first < 0) first = cyc;
                if (stalled) chk("r_stall_hold", {bus.rdata_o, bus.rresp_o, bus.rlast_o}, held);
                if (rr) begin
                    chk("r_data", bus.rdata_o, exp_d[k]);
                    chk("r_resp", bus.rresp_o, exp_r[k]);
                    chk("r_last", bus.rlast_o, k == int'(len));
                    chk("r_id", bus.rid_o, id);
                    if (k == 0) d0 = bus.rdata_o;
                    k++; stalled = 0; last_hs = cyc;
                end else begin
                    stalled = 1;
                    held = {bus.rdata_o, bus.rresp_o, bus.rlast_o};
                end
            end
            @(negedge clk);
            n++;
        end
        bus.rready_i = 0;
        chk("r_beats", k, int'(len) + 1);
        chk("r_done_valid", bus.rvalid_o, 1'b0);
        chk("r_done_arready", bus.arready_o, 1'b1);
        r_lat = first - c0;
        span  = last_hs - first + 1;
    endtask

    int blat, blat2, rlat, rlat2, span, span2, n, k;
    logic [31:0] d0, d0b, addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    int          sw;

    initial begin
        rst = 1;
        bus.awid_i = 0; bus.awaddr_i = 0; bus.awlen_i = 0; bus.awsize_i = 0; bus.awburst_i = 0;
        bus.awvalid_i = 0; bus.wid_i = 0; bus.wdata_i = 0; bus.wstrb_i = 0; bus.wlast_i = 0;
        bus.wvalid_i = 0; bus.bready_i = 0; bus.arid_i = 0; bus.araddr_i = 0; bus.arlen_i = 0;
        bus.arsize_i = 0; bus.arburst_i = 0; bus.arvalid_i = 0; bus.rready_i = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {bus.awready_o, bus.arready_o, bus.wready_o, bus.bvalid_o, bus.rvalid_o, bus.rlast_o}, 6'b110000);
        chk("rst_ids", {bus.bid_o, bus.bresp_o, bus.rid_o, bus.rresp_o}, 12'd0);
        chk("rst_rdata", bus.rdata_o, 32'd0);
        rst = 0;

        // single write / read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(4'h3, 32'h10, 4'd0, 2'b01, 3'b010, wd, ws, 0, 1, blat);
        chk("t1_b_latency", blat, 2);
        axi_read(4'h5, 32'h10, 4'd0, 2'b01, 3'b010, 0, rlat, span, d0);
        chk("t1_rdata", d0, 32'hDEADBEEF);
        chk("t1_r_latency", rlat, 1);

        // 16-beat INCR burst, full-rate read
        for (int i = 0; i < 16; i++) begin wd[i] = i; ws[i] = 4'hF; end
        axi_write(4'h1, 32'h100, 4'd15, 2'b01, 3'b010, wd, ws, 0, 0, blat);
        axi_read(4'h2, 32'h100, 4'd15, 2'b01, 3'b010, 0, rlat, span, d0);
        chk("t2_span", span, 16);
        chk("t2_r_latency", rlat, 1);

        // strobe merge and backpressure
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        axi_write(4'h4, 32'h200, 4'd0, 2'b01, 3'b010, wd, ws, 0, 0, blat);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        axi_write(4'h4, 32'h200, 4'd0, 2'b01, 3'b010, wd, ws, 0, 2, blat);
        axi_read(4'h6, 32'h200, 4'd0, 2'b01, 3'b010, 1, rlat, span, d0);
        chk("t3_strobe", d0, 32'hFF22FF44);
        axi_read(4'h6, 32'h100, 4'd15, 2'b01, 3'b010, 1, rlat, span, d0);

        // error paths and address boundaries
        wd[0] = 32'hA5A5_0000; ws[0] = 4'hF;
        axi_write(4'h0, 32'h0, 4'd0, 2'b01, 3'b010, wd, ws, 0, 0, blat);
        wd[0] = 32'hC0FFEE03; ws[0] = 4'hF; wd[1] = 32'h0BAD0BAD; ws[1] = 4'hF;
        axi_write(4'h8, 32'hFFC, 4'd1, 2'b01, 3'b010, wd, ws, 0, 0, blat);
        axi_read(4'h9, 32'hFFC, 4'd1, 2'b01, 3'b010, 0, rlat, span, d0);
        chk("t4_last_word", d0, 32'hC0FFEE03);
        axi_read(4'h9, 32'hFFFF_FFFC, 4'd1, 2'b01, 3'b010, 0, rlat, span, d0);
        wd[0] = 32'h12345678;
        axi_write(4'hA, 32'h10, 4'd0, 2'b10, 3'b010, wd, ws, 0, 0, blat);
        axi_write(4'hB, 32'h10, 4'd0, 2'b01, 3'b001, wd, ws, 0, 0, blat);
        axi_read(4'hC, 32'h10, 4'd0, 2'b01, 3'b010, 0, rlat, span, d0);
        chk("t4_wrap_unchanged", d0, 32'hDEADBEEF);
        axi_read(4'hC, 32'h100, 4'd3, 2'b10, 3'b010, 0, rlat, span, d0);
        wd[0] = 32'h0000_00AA; wd[1] = 32'h0000_00BB;
        axi_write(4'hD, 32'h20, 4'd1, 2'b01, 3'b010, wd, ws, 1, 0, blat);
        axi_read(4'hD, 32'h20, 4'd1, 2'b00, 3'b010, 0, rlat, span, d0);

        // AR and AW to the same word in the same cycle
        wd[0] = 32'hFEEDF00D; ws[0] = 4'hF;
        fork
            axi_write(4'hE, 32'h10, 4'd0, 2'b01, 3'b010, wd, ws, 0, 0, blat2);
            axi_read(4'hF, 32'h10, 4'd0, 2'b01, 3'b010, 0, rlat2, span2, d0b);
        join
        chk("t5_read_old", d0b, 32'hDEADBEEF);
        axi_read(4'hF, 32'h10, 4'd0, 2'b01, 3'b010, 0, rlat, span, d0);
        chk("t5_read_new", d0, 32'hFEEDF00D);

        // reset in the middle of an 8-beat read
        @(negedge clk);
        bus.arid_i = 4'h7; bus.araddr_i = 32'h100; bus.arlen_i = 4'd7;
        bus.arburst_i = 2'b01; bus.arsize_i = 3'b010; bus.arvalid_i = 1;
        @(negedge clk);
        bus.arvalid_i = 0; bus.rready_i = 1; k = 0; n = 0;
        while (k < 3 && n < 50) begin
            if (bus.rvalid_o) begin chk("t6_beat", bus.rdata_o, ref_mem[64 + k]); k++; end
            @(negedge clk);
            n++;
        end
        chk("t6_beat3", {bus.rvalid_o, bus.rdata_o[30:0]}, {1'b1, ref_mem[67][30:0]});
        bus.rready_i = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        chk("t6_after_rst", {bus.rvalid_o, bus.arready_o, bus.rlast_o, bus.awready_o, bus.bvalid_o}, 5'b01010);
        chk("t6_after_rst_data", {bus.rdata_o[29:0], bus.rresp_o}, 32'd0);
        axi_read(4'h7, 32'h100, 4'd7, 2'b01, 3'b010, 0, rlat, span, d0);
        chk("t6_new_span", span, 8);

        // randomized traffic in words 512..767, seeded with full-strobe bursts
        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            axi_write(4'($urandom), 32'h800 + 32'(blk * 64), 4'd15, 2'b01, 3'b010, wd, ws, 0, 0, blat);
        end
        for (int it = 0; it < 25; it++) begin
            len   = 4'($urandom_range(0, 15));
            burst = $urandom_range(0, 1) ? 2'b01 : 2'b00;
            sw    = $urandom_range(512, 767);
            if (burst == 2'b01 && sw + int'(len) > 767) sw = 767 - int'(len);
            addr  = 32'(sw * 4) | 32'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            axi_write(4'($urandom), addr, len, burst, 3'b010, wd, ws, 0, $urandom_range(0, 2), blat);
            len   = 4'($urandom_range(0, 15));
            burst = $urandom_range(0, 1) ? 2'b01 : 2'b00;
            sw    = $urandom_range(512, 767);
            if (burst == 2'b01 && sw + int'(len) > 767) sw = 767 - int'(len);
            axi_read(4'($urandom), 32'(sw * 4), len, burst, 3'b010, 2, rlat, span, d0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
